// File: rtl/controller_pkg.sv
// Shared definitions for controller_feedback: channel mode encoding, CPU write
// word field positions and player count.
package controller_pkg;

  localparam int NUM_PLAYERS = 4;

  localparam int PLAYER_HI  = 15;
  localparam int PLAYER_LO  = 14;
  localparam int MODE_HI    = 13;
  localparam int MODE_LO    = 12;
  localparam int PATTERN_HI = 7;
  localparam int PATTERN_LO = 0;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'b00,
    MODE_SOLID = 2'b01,
    MODE_BLINK = 2'b10,
    MODE_PULSE = 2'b11
  } mode_e;

  function automatic logic [1:0] field_player(input logic [15:0] word);
    return word[PLAYER_HI:PLAYER_LO];
  endfunction

  function automatic mode_e field_mode(input logic [15:0] word);
    return mode_e'(word[MODE_HI:MODE_LO]);
  endfunction

  function automatic logic [7:0] field_pattern(input logic [15:0] word);
    return word[PATTERN_HI:PATTERN_LO];
  endfunction

endpackage

// File: rtl/led_channel.sv
// One player's LED channel: mode state machine, pattern register, pulse timer
// and a registered 8-bit LED slice.
module led_channel
  import controller_pkg::*;
#(
  parameter int PULSE_LEN = 12500000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_i,
  input  mode_e      mode_i,
  input  logic [7:0] pattern_i,
  input  logic       blink_phase_i,
  output logic [7:0] led_o,
  output mode_e      mode_o,
  output logic [7:0] pattern_o
);

  localparam int TW = (PULSE_LEN > 1) ? $clog2(PULSE_LEN) : 1;
  localparam logic [TW-1:0] TIMER_LOAD = TW'(PULSE_LEN - 1);

  mode_e         mode_q, mode_d;
  logic [7:0]    pattern_q, pattern_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [7:0]    led_q, led_d;

  // A write always wins over pulse expiry in the same cycle.
  always_comb begin
    mode_d    = mode_q;
    pattern_d = pattern_q;
    timer_d   = timer_q;
    if (wr_i) begin
      mode_d    = mode_i;
      pattern_d = pattern_i;
      timer_d   = (mode_i == MODE_PULSE) ? TIMER_LOAD : '0;
    end else if (mode_q == MODE_PULSE) begin
      if (timer_q == '0) mode_d = MODE_OFF;
      else               timer_d = timer_q - 1'b1;
    end
  end

  // The LED slice is computed from next state so it updates alongside wr_ack
  // and in step with the registered blink phase.
  always_comb begin
    led_d = '0;
    case (mode_d)
      MODE_OFF:   led_d = '0;
      MODE_SOLID: led_d = pattern_d;
      MODE_BLINK: led_d = pattern_d & {8{blink_phase_i}};
      MODE_PULSE: led_d = pattern_d;
      default:    led_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q    <= MODE_OFF;
      pattern_q <= '0;
      timer_q   <= '0;
      led_q     <= '0;
    end else begin
      mode_q    <= mode_d;
      pattern_q <= pattern_d;
      timer_q   <= timer_d;
      led_q     <= led_d;
    end
  end

  assign led_o     = led_q;
  assign mode_o    = mode_q;
  assign pattern_o = pattern_q;

endmodule

// File: rtl/controller_feedback.sv
// Four-player controller LED feedback block: shared blink divider, write ack and
// four led_channel instances. Optional readback port under CTRL_FEEDBACK_READBACK_EN.
module controller_feedback
  import controller_pkg::*;
#(
  parameter int BLINK_DIV = 25000000,
  parameter int PULSE_LEN = 12500000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_en,
  input  logic [15:0] wr_data,
  output logic        wr_ack,
  output logic [31:0] led_out,
  output logic        blink_phase
`ifdef CTRL_FEEDBACK_READBACK_EN
  ,
  input  logic [1:0]  rd_sel,
  output logic [15:0] rd_data
`endif
);

  localparam int CW = $clog2(BLINK_DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(BLINK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          phase_q, phase_d;
  logic          ack_q;

  logic [NUM_PLAYERS-1:0][1:0] mode_w;
  logic [NUM_PLAYERS-1:0][7:0] pattern_w;

  wire unused_reserved = ^wr_data[11:8];

  // Free-running divider; writes never disturb it.
  always_comb begin
    cnt_d   = cnt_q + 1'b1;
    phase_d = phase_q;
    if (cnt_q == CNT_MAX) begin
      cnt_d   = '0;
      phase_d = ~phase_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      ack_q   <= wr_en;
    end
  end

  assign wr_ack      = ack_q;
  assign blink_phase = phase_q;

  for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_chan
    mode_e chan_mode;

    led_channel #(
      .PULSE_LEN(PULSE_LEN)
    ) u_chan (
      .clk          (clk),
      .rst_n        (rst_n),
      .wr_i         (wr_en && (field_player(wr_data) == 2'(p))),
      .mode_i       (field_mode(wr_data)),
      .pattern_i    (field_pattern(wr_data)),
      .blink_phase_i(phase_d),
      .led_o        (led_out[8*p +: 8]),
      .mode_o       (chan_mode),
      .pattern_o    (pattern_w[p])
    );

    assign mode_w[p] = chan_mode;
  end

`ifdef CTRL_FEEDBACK_READBACK_EN
  assign rd_data = {rd_sel, mode_w[rd_sel], 4'b0000, pattern_w[rd_sel]};
`else
  wire unused_readback = ^{mode_w, pattern_w};
`endif

endmodule

// File: tb/tb_controller_feedback.sv
// Directed + random bench for controller_feedback (BLINK_DIV=4, PULSE_LEN=6)
// against a cycle-count reference model.
module tb_controller_feedback;

  localparam int BD = 4;
  localparam int PL = 6;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_en = 1'b0;
  logic [15:0] wr_data = '0;
  logic        wr_ack;
  logic [31:0] led_out;
  logic        blink_phase;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: per-player mode/pattern, remaining pulse cycles, edges since reset.
  int m_mode[4];
  int m_pat[4];
  int m_left[4];
  int m_edges;
  bit m_ack;

  always #5 clk = ~clk;

  controller_feedback #(
    .BLINK_DIV(BD),
    .PULSE_LEN(PL)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .wr_ack     (wr_ack),
    .led_out    (led_out),
    .blink_phase(blink_phase)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int p = 0; p < 4; p++) begin
      m_mode[p] = 0;
      m_pat[p]  = 0;
      m_left[p] = 0;
    end
    m_edges = 0;
    m_ack   = 1'b0;
  endfunction

  function automatic logic exp_phase();
    return logic'((m_edges / BD) % 2);
  endfunction

  function automatic logic [31:0] exp_led();
    logic [31:0] e;
    logic [7:0]  pat;
    e = '0;
    for (int p = 0; p < 4; p++) begin
      pat = 8'(m_pat[p]);
      case (m_mode[p])
        1:       e[8*p +: 8] = pat;
        2:       e[8*p +: 8] = exp_phase() ? pat : 8'h00;
        3:       e[8*p +: 8] = pat;
        default: e[8*p +: 8] = 8'h00;
      endcase
    end
    return e;
  endfunction

  function automatic void model_edge(input bit we, input logic [15:0] d);
    m_edges++;
    m_ack = we;
    for (int p = 0; p < 4; p++) begin
      if (we && int'(d[15:14]) == p) begin
        m_mode[p] = int'(d[13:12]);
        m_pat[p]  = int'(d[7:0]);
        m_left[p] = (m_mode[p] == 3) ? PL : 0;
      end else if (m_mode[p] == 3) begin
        m_left[p]--;
        if (m_left[p] == 0) m_mode[p] = 0;
      end
    end
  endfunction

  task automatic check_all(input string tag);
    check({tag, ".led"},   led_out,            exp_led());
    check({tag, ".ack"},   {31'b0, wr_ack},     {31'b0, m_ack});
    check({tag, ".phase"}, {31'b0, blink_phase}, {31'b0, exp_phase()});
  endtask

  // Called on a falling edge; drives one cycle of input and checks after the next rise.
  task automatic tick(input bit we, input logic [15:0] d, input string tag);
    wr_en   = we;
    wr_data = d;
    @(posedge clk);
    model_edge(we, d);
    @(negedge clk);
    wr_en   = 1'b0;
    wr_data = '0;
    check_all(tag);
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) tick(1'b0, 16'h0000, tag);
  endtask

  initial begin
    model_reset();
    #12;
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;

    tick(1'b1, 16'h50A5, "solid_wr");
    check("solid_const", led_out, 32'h0000A500);
    idle(5, "solid_hold");

    tick(1'b1, 16'hA0FF, "blink_wr");
    idle(12, "blink_run");

    tick(1'b1, 16'hF03C, "pulse_wr");
    idle(5, "pulse_on");
    check("pulse_last_on", {24'b0, led_out[31:24]}, 32'h3C);
    tick(1'b0, 16'h0000, "pulse_expire");
    check("pulse_off", {24'b0, led_out[31:24]}, 32'h00);
    idle(2, "pulse_after");

    tick(1'b1, 16'hF03C, "restart_wr");
    idle(3, "restart_on");
    tick(1'b1, 16'hF0C3, "restart_rewr");
    idle(5, "restart_ext");
    check("restart_still_on", {24'b0, led_out[31:24]}, 32'hC3);
    idle(3, "restart_end");

    tick(1'b1, 16'h1011, "b2b_p0");
    tick(1'b1, 16'h5022, "b2b_p1");
    tick(1'b1, 16'hA033, "b2b_p2");
    tick(1'b1, 16'hF044, "b2b_p3");
    idle(8, "b2b_after");

    tick(1'b1, 16'hF055, "coll_pulse");
    idle(5, "coll_on");
    tick(1'b1, 16'hD066, "coll_wr");
    check("coll_wins", {24'b0, led_out[31:24]}, 32'h66);
    idle(4, "coll_hold");

    for (int i = 0; i < 300; i++)
      tick(1'(($urandom_range(0, 3)) != 0), 16'($urandom), "rand");

    // Reset asserted between edges, mid-pulse and with a write pending.
    tick(1'b1, 16'hF077, "pre_rst_pulse");
    wr_en   = 1'b1;
    wr_data = 16'h7012;
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all("async_rst");
    @(negedge clk);
    wr_en   = 1'b0;
    wr_data = '0;
    @(negedge clk);
    check_all("in_rst");
    rst_n = 1'b1;
    tick(1'b0, 16'h0000, "post_rst_idle");
    tick(1'b1, 16'h6081, "post_rst_wr");

    for (int i = 0; i < 100; i++)
      tick(1'(($urandom_range(0, 1)) != 0), 16'($urandom), "rand2");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/controller_feedback.md
CONTROLLER_FEEDBACK -- requirements
Module: controller_feedback

Interface
REQ-001 Parameter BLINK_DIV, default 25000000: blink half-period in clk cycles, legal range 2 or more.
REQ-002 Parameter PULSE_LEN, default 12500000: pulse-once on-time in clk cycles, legal range 1 or more.
REQ-003 clk  in  1  the single system clock; all state changes on its rising edge.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 wr_en  in  1  CPU write strobe; a write is accepted on every clk edge where wr_en=1.
REQ-006 wr_data  in  16  [15:14] player, [13:12] mode, [11:8] reserved (ignored), [7:0] LED pattern.
REQ-007 wr_ack  out  1  one-cycle pulse in the cycle after an accepted write.
REQ-008 led_out  out  32  controller LED drive; player p occupies bits [8p+7:8p].
REQ-009 blink_phase  out  1  current shared blink phase.

Function
REQ-010 Mode encoding SHALL be: 00 OFF, 01 SOLID, 10 BLINK, 11 PULSE.
REQ-011 Each of the 4 players SHALL hold a 2-bit mode register and an 8-bit pattern register.
REQ-012 An accepted write SHALL load mode and pattern of the addressed player only; other players remain unchanged.
REQ-013 Write-to-output latency SHALL be 1 cycle: led_out reflects the new value in the same cycle that wr_ack is high.
REQ-014 Back-to-back writes on consecutive cycles SHALL all be accepted, with wr_ack high on each following cycle.
REQ-015 led_out slice SHALL be 0 in OFF, pattern in SOLID, pattern AND {8{blink_phase}} in BLINK, and pattern while the PULSE timer runs.
REQ-016 All led_out bits SHALL be registered outputs, with no combinational path from wr_data.
REQ-017 The blink counter SHALL count 0 to BLINK_DIV-1 and then wrap to 0; blink_phase SHALL toggle on each wrap.
REQ-018 The blink counter SHALL free-run, and a write SHALL neither reset the counter nor change blink_phase.
REQ-019 Channel state machine (per player): OFF, SOLID, BLINK, PULSE; any write moves the channel to the written mode from any state.
REQ-020 Entering PULSE SHALL load the timer with PULSE_LEN-1.
REQ-021 The PULSE timer SHALL decrement each cycle; at 0 the channel SHALL go to OFF on the next edge with the pattern retained.
REQ-022 The pattern SHALL therefore drive for exactly PULSE_LEN cycles.
REQ-023 A PULSE write during an active pulse SHALL restart the timer with the new pattern.
REQ-024 If a write to a player coincides with its pulse expiry, the write SHALL win.
REQ-025 Counter widths SHALL be sized by $clog2 of the parameter, with no truncation at the maximum value.

Reset
REQ-026 While rst_n=0, and asynchronously on its falling edge, the block SHALL be forced to its reset values: all modes OFF, patterns 0, timers 0, blink counter 0.
REQ-027 Reset output values SHALL be blink_phase=0, wr_ack=0 and led_out=0.
REQ-028 Reset asserted mid-pulse or mid-write SHALL abort the operation with no wr_ack produced afterwards.
REQ-029 The first write SHALL be accepted on the first clk edge with rst_n=1.

Configuration
REQ-030 With CTRL_FEEDBACK_READBACK_EN defined, the block SHALL add input rd_sel (2 bits) and output rd_data (16 bits).
REQ-031 In that case rd_data SHALL be {2'b player, mode, 4'b0, pattern} of the selected player, combinational from the registers; during PULSE it reports 11 until expiry, then 00.
REQ-032 Without CTRL_FEEDBACK_READBACK_EN, these ports and their logic SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-033 The shared package controller_pkg SHALL hold the mode encoding constants, the wr_data field positions and the player count (4).
REQ-034 Sub-module led_channel SHALL hold one player's mode, pattern and pulse timer, taking blink_phase as an input, and SHALL be instantiated 4 times.
REQ-035 The blink divider and the wr_ack register SHALL reside in the top level.

Verification (bench with BLINK_DIV=4, PULSE_LEN=6)
REQ-036 Reset check: rst_n=0 mid-run -> led_out=0, wr_ack=0 and blink_phase=0 immediately, without waiting for a clk edge.
REQ-037 SOLID write: wr_data=16'h50A5 (player 1, SOLID, A5) -> next cycle wr_ack=1 and led_out=32'h0000A500; it holds indefinitely.
REQ-038 BLINK write: wr_data=16'hA0FF (player 2, BLINK) -> led_out[23:16] alternates FF/00 every 4 cycles, in lockstep with blink_phase.
REQ-039 PULSE write: wr_data=16'hF03C (player 3) -> led_out[31:24]=3C for exactly 6 cycles, then 00 with mode OFF; a re-write at cycle 4 extends it to 4+6 cycles.
REQ-040 Simultaneous events: writes to players 0,1,2,3 on 4 consecutive cycles -> 4 wr_ack pulses, each slice updating 1 cycle after its write; a write coinciding with pulse expiry leaves the written mode active.
